// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-lite response encodings
package axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_regfile_slave.sv
// rtl/axil_regfile_slave.sv - AXI4-lite slave backed by a flat bank of read/write registers
module axil_regfile_slave
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int REG_COUNT  = 16
) (
  input  logic                             clk,
  input  logic                             rst,

  input  logic [ADDR_WIDTH-1:0]            s_axil_awaddr,
  input  logic [2:0]                       s_axil_awprot,
  input  logic                             s_axil_awvalid,
  output logic                             s_axil_awready,

  input  logic [DATA_WIDTH-1:0]            s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]            s_axil_wstrb,
  input  logic                             s_axil_wvalid,
  output logic                             s_axil_wready,

  output logic [1:0]                       s_axil_bresp,
  output logic                             s_axil_bvalid,
  input  logic                             s_axil_bready,

  input  logic [ADDR_WIDTH-1:0]            s_axil_araddr,
  input  logic [2:0]                       s_axil_arprot,
  input  logic                             s_axil_arvalid,
  output logic                             s_axil_arready,

  output logic [DATA_WIDTH-1:0]            s_axil_rdata,
  output logic [1:0]                       s_axil_rresp,
  output logic                             s_axil_rvalid,
  input  logic                             s_axil_rready,

  output logic [REG_COUNT*DATA_WIDTH-1:0]  reg_q,
  output logic [REG_COUNT-1:0]             reg_wr
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int IDX_W    = $clog2(REG_COUNT);
  localparam int TOP_LSB  = ADDR_LSB + IDX_W;

  // Out of range when the word index is past the bank or any address bit above it is set.
  function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] hi;
    hi = addr >> TOP_LSB;
    return (hi != '0) || (int'(addr[ADDR_LSB +: IDX_W]) >= REG_COUNT);
  endfunction

  logic                            en_q;
  logic                            aw_full_q;
  logic [IDX_W-1:0]                aw_idx_q;
  logic                            aw_err_q;
  logic                            w_full_q;
  logic [DATA_WIDTH-1:0]           w_data_q;
  logic [STRB_WIDTH-1:0]           w_strb_q;
  logic                            bvalid_q;
  logic [1:0]                      bresp_q;
  logic                            rvalid_q;
  logic [DATA_WIDTH-1:0]           rdata_q;
  logic [1:0]                      rresp_q;
  logic [REG_COUNT*DATA_WIDTH-1:0] regs_q;
  logic [REG_COUNT-1:0]            reg_wr_q;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic commit;
  logic unused_prot;

  assign s_axil_awready = en_q && !aw_full_q;
  assign s_axil_wready  = en_q && !w_full_q;
  assign s_axil_arready = en_q && (!rvalid_q || s_axil_rready);

  assign aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_hs  = s_axil_wvalid  && s_axil_wready;
  assign ar_hs = s_axil_arvalid && s_axil_arready;

  // A held write commits once both halves are in and the B slot is free or draining.
  assign commit = aw_full_q && w_full_q && (!bvalid_q || s_axil_bready);

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;
  assign reg_q         = regs_q;
  assign reg_wr        = reg_wr_q;

  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  // Enable comes up one cycle after reset release so readies stay low that first cycle.
  always_ff @(posedge clk) begin
    if (rst) en_q <= 1'b0;
    else     en_q <= 1'b1;
  end

  // AW holding register: captured on handshake, emptied by commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_err_q  <= 1'b0;
    end else if (aw_hs) begin
      aw_full_q <= 1'b1;
      aw_idx_q  <= s_axil_awaddr[ADDR_LSB +: IDX_W];
      aw_err_q  <= addr_oor(s_axil_awaddr);
    end else if (commit) begin
      aw_full_q <= 1'b0;
    end
  end

  // W holding register: captured on handshake, emptied by commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_full_q <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (w_hs) begin
      w_full_q <= 1'b1;
      w_data_q <= s_axil_wdata;
      w_strb_q <= s_axil_wstrb;
    end else if (commit) begin
      w_full_q <= 1'b0;
    end
  end

  // B response: a commit always (re)loads it, otherwise it drops on bready.
  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid_q <= 1'b0;
      bresp_q  <= AXI_RESP_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= aw_err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    end else if (s_axil_bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // Register bank update with byte strobes, plus the one-cycle write pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q   <= '0;
      reg_wr_q <= '0;
    end else begin
      reg_wr_q <= '0;
      if (commit && !aw_err_q) begin
        reg_wr_q[aw_idx_q] <= 1'b1;
        for (int k = 0; k < STRB_WIDTH; k++) begin
          if (w_strb_q[k]) begin
            regs_q[int'(aw_idx_q)*DATA_WIDTH + k*8 +: 8] <= w_data_q[k*8 +: 8];
          end
        end
      end
    end
  end

  // R response: loaded on AR handshake from the pre-edge bank contents, held until rready.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= AXI_RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      if (addr_oor(s_axil_araddr)) begin
        rdata_q <= '0;
        rresp_q <= AXI_RESP_SLVERR;
      end else begin
        rdata_q <= regs_q[int'(s_axil_araddr[ADDR_LSB +: IDX_W])*DATA_WIDTH +: DATA_WIDTH];
        rresp_q <= AXI_RESP_OKAY;
      end
    end else if (s_axil_rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_regfile_slave.sv
// tb/tb_axil_regfile_slave.sv - scoreboard bench for axil_regfile_slave
module tb_axil_regfile_slave;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  s_axil_awaddr = '0;
  logic [2:0]   s_axil_awprot = '0;
  logic         s_axil_awvalid = 1'b0;
  logic         s_axil_awready;
  logic [31:0]  s_axil_wdata = '0;
  logic [3:0]   s_axil_wstrb = '0;
  logic         s_axil_wvalid = 1'b0;
  logic         s_axil_wready;
  logic [1:0]   s_axil_bresp;
  logic         s_axil_bvalid;
  logic         s_axil_bready = 1'b1;
  logic [15:0]  s_axil_araddr = '0;
  logic [2:0]   s_axil_arprot = '0;
  logic         s_axil_arvalid = 1'b0;
  logic         s_axil_arready;
  logic [31:0]  s_axil_rdata;
  logic [1:0]   s_axil_rresp;
  logic         s_axil_rvalid;
  logic         s_axil_rready = 1'b1;
  logic [511:0] reg_q;
  logic [15:0]  reg_wr;

  int checks = 0;
  int errors = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  logic [15:0] wr_acc = '0;

  axil_regfile_slave dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .reg_q(reg_q), .reg_wr(reg_wr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_at(input int i);
    return reg_q[i*32 +: 32];
  endfunction

  // Response monitor: pops the scoreboard on every B/R handshake, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      wr_acc <= wr_acc | reg_wr;
      if (s_axil_bvalid && s_axil_bready) begin
        if (bq.size() == 0) chk("b_unexpected", 1'b1, 1'b0);
        else chk("bresp", s_axil_bresp, bq.pop_front());
      end
      if (s_axil_rvalid && s_axil_rready) begin
        if (rq.size() == 0) chk("r_unexpected", 1'b1, 1'b0);
        else chk("rdata_rresp", {s_axil_rdata, s_axil_rresp}, rq.pop_front());
      end
    end
  end

  task automatic aw_send(input logic [15:0] addr);
    bit got = 0;
    s_axil_awaddr  = addr;
    s_axil_awvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_axil_awready) begin got = 1; break; end
    end
    if (!got) chk("aw_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb);
    bit got = 0;
    s_axil_wdata  = data;
    s_axil_wstrb  = strb;
    s_axil_wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_axil_wready) begin got = 1; break; end
    end
    if (!got) chk("w_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    s_axil_wvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [15:0] addr);
    bit got = 0;
    s_axil_araddr  = addr;
    s_axil_arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_axil_arready) begin got = 1; break; end
    end
    if (!got) chk("ar_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    s_axil_arvalid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] snap;
    logic [15:0]  raddr [3];
    logic [31:0]  rexp  [3];
    raddr[0] = 16'h0000; raddr[1] = 16'h0004; raddr[2] = 16'h0008;
    rexp[0]  = 32'h0;    rexp[1]  = 32'hDEADBEEF; rexp[2] = 32'h00220044;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", s_axil_awready, 1'b0);
    chk("rst_bvalid", s_axil_bvalid, 1'b0);
    chk("rst_rvalid", s_axil_rvalid, 1'b0);
    chk("rst_reg_q", reg_q, '0);
    chk("rst_reg_wr", reg_wr, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", s_axil_awready, 1'b0);
    chk("post_rst_wready", s_axil_wready, 1'b0);
    chk("post_rst_arready", s_axil_arready, 1'b0);
    @(posedge clk); #1;

    // 1: simultaneous AW/W
    bq.push_back(2'b00);
    fork
      aw_send(16'h0004);
      w_send(32'hDEADBEEF, 4'hF);
    join
    @(negedge clk);
    chk("t1_bvalid_early", s_axil_bvalid, 1'b0);
    @(negedge clk);
    chk("t1_bvalid", s_axil_bvalid, 1'b1);
    chk("t1_reg1", reg_at(1), 32'hDEADBEEF);
    chk("t1_reg_wr", reg_wr, 16'h0002);
    @(negedge clk);
    chk("t1_reg_wr_clear", reg_wr, 16'h0000);
    @(posedge clk); #1;

    // 2: AW three cycles ahead of W, partial strobes
    bq.push_back(2'b00);
    aw_send(16'h0008);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_awready_held", s_axil_awready, 1'b0);
    end
    @(posedge clk); #1;
    w_send(32'h11223344, 4'h5);
    @(negedge clk);
    @(negedge clk);
    chk("t2_reg2", reg_at(2), 32'h00220044);
    chk("t2_reg_wr", reg_wr, 16'h0004);
    @(posedge clk); #1;

    // 3: out-of-range write and read
    snap = reg_q;
    wr_acc = '0;
    bq.push_back(2'b10);
    fork
      aw_send(16'h0040);
      w_send(32'hFFFFFFFF, 4'hF);
    join
    repeat (3) @(negedge clk);
    chk("t3_reg_q_unchanged", reg_q, snap);
    chk("t3_reg_wr_none", wr_acc, 16'h0000);
    @(posedge clk); #1;
    rq.push_back({32'h0, 2'b10});
    ar_send(16'h0040);
    @(negedge clk);
    @(posedge clk); #1;

    // 4: B back-pressure with a second write queued
    s_axil_bready = 1'b0;
    bq.push_back(2'b00);
    fork
      aw_send(16'h000C);
      w_send(32'hA5A5A5A5, 4'hF);
    join
    bq.push_back(2'b00);
    fork
      aw_send(16'h0010);
      w_send(32'h0BADF00D, 4'hF);
    join
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_bvalid_hold", s_axil_bvalid, 1'b1);
      chk("t4_bresp_hold", s_axil_bresp, 2'b00);
      chk("t4_awready_blocked", s_axil_awready, 1'b0);
      chk("t4_wready_blocked", s_axil_wready, 1'b0);
      chk("t4_reg4_pending", reg_at(4), 32'h0);
    end
    @(posedge clk); #1;
    s_axil_bready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_bvalid_second", s_axil_bvalid, 1'b1);
    chk("t4_reg4", reg_at(4), 32'h0BADF00D);
    chk("t4_reg_wr", reg_wr, 16'h0010);
    @(negedge clk);
    chk("t4_bvalid_drained", s_axil_bvalid, 1'b0);
    @(posedge clk); #1;

    // 5: back-to-back reads, then R back-pressure
    s_axil_arvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_axil_araddr = raddr[i];
      rq.push_back({rexp[i], 2'b00});
      @(negedge clk);
      chk("t5_arready", s_axil_arready, 1'b1);
      if (i > 0) chk("t5_rvalid_stream", s_axil_rvalid, 1'b1);
      @(posedge clk); #1;
    end
    s_axil_arvalid = 1'b0;
    @(negedge clk);
    chk("t5_rvalid_last", s_axil_rvalid, 1'b1);
    @(negedge clk);
    chk("t5_rvalid_idle", s_axil_rvalid, 1'b0);
    @(posedge clk); #1;
    s_axil_rready  = 1'b0;
    s_axil_arvalid = 1'b1;
    s_axil_araddr  = 16'h0004;
    rq.push_back({32'hDEADBEEF, 2'b00});
    @(negedge clk);
    chk("t5_arready_bp0", s_axil_arready, 1'b1);
    @(posedge clk); #1;
    s_axil_araddr = 16'h000C;
    rq.push_back({32'hA5A5A5A5, 2'b00});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_arready_bp", s_axil_arready, 1'b0);
      chk("t5_rdata_hold", s_axil_rdata, 32'hDEADBEEF);
    end
    @(posedge clk); #1;
    s_axil_rready = 1'b1;
    @(negedge clk);
    chk("t5_arready_release", s_axil_arready, 1'b1);
    @(posedge clk); #1;
    s_axil_arvalid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;

    // 6: reset with AW held and R pending
    aw_send(16'h0000);
    s_axil_rready = 1'b0;
    ar_send(16'h0004);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_bvalid", s_axil_bvalid, 1'b0);
    chk("t6_rvalid", s_axil_rvalid, 1'b0);
    chk("t6_reg_q", reg_q, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_awready_first", s_axil_awready, 1'b0);
    chk("t6_wready_first", s_axil_wready, 1'b0);
    chk("t6_arready_first", s_axil_arready, 1'b0);
    @(posedge clk); #1;
    s_axil_rready = 1'b1;
    w_send(32'h12345678, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_stale_commit", s_axil_bvalid, 1'b0);
      chk("t6_reg0_empty", reg_at(0), 32'h0);
    end
    @(posedge clk); #1;
    bq.push_back(2'b00);
    aw_send(16'h0000);
    @(negedge clk);
    @(negedge clk);
    chk("t6_reg0", reg_at(0), 32'h12345678);

    repeat (4) @(negedge clk);
    chk("b_queue_empty", bq.size(), 0);
    chk("r_queue_empty", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
